// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
// Contents: FSM state encoding used by serial_adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        SA_IDLE = 2'd0,
        SA_RUN  = 2'd1,
        SA_DONE = 2'd2
    } sa_state_e;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full-adder cell, the only arithmetic in the serial adder.
// Ports:
//   x, y  - operand bits
//   ci    - carry in
//   s     - sum bit
//   co    - carry out
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = x ^ y;
    assign s  = p ^ ci;
    assign co = (x & y) | (ci & p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: captures a, b, cin over a valid/ready handshake,
// adds LSB-first through one full-adder cell, one bit per clock, then holds
// sum/cout behind a valid/ready output handshake.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   in_valid / in_ready   - operand handshake (ready only in IDLE)
//   a, b, cin             - operands, sampled at the acceptance edge only
//   out_valid / out_ready - result handshake (valid only in DONE)
//   sum, cout             - (a + b + cin) mod 2^WIDTH and its carry out
//   busy                  - high in RUN or DONE
//
// state   | meaning
// --------+---------------------------------------------------------
// SA_IDLE | waiting for operands, in_ready=1
// SA_RUN  | shifting one bit per clock through the full adder
// SA_DONE | result presented, waiting for out_ready
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sa_state_e        state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    // Only WIDTH-1 partial sum bits need storing; the final bit comes
    // straight from the full adder on the last RUN edge.
    logic [WIDTH-2:0] sum_sh_q;
    logic [WIDTH-1:0] sum_sh_d;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             fa_s;
    logic             fa_co;

    full_adder u_fa (
        .x  (a_sh_q[0]),
        .y  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    assign sum_sh_d = {fa_s, sum_sh_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SA_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_sh_q    <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                SA_IDLE: begin
                    if (in_valid) begin
                        a_sh_q     <= a;
                        b_sh_q     <= b;
                        carry_q    <= cin;
                        sum_sh_q   <= '0;
                        cnt_q      <= '0;
                        state_q    <= SA_RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                SA_RUN: begin
                    a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
                    sum_sh_q <= sum_sh_d[WIDTH-1:1];
                    carry_q  <= fa_co;
                    if (cnt_q == CNT_LAST) begin
                        // Result registers only move here, so sum/cout stay
                        // stable through DONE and the following IDLE/RUN.
                        sum_q       <= sum_sh_d;
                        cout_q      <= fa_co;
                        state_q     <= SA_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                SA_DONE: begin
                    if (out_ready) begin
                        state_q     <= SA_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= SA_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    parameter int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int     tests = 0;
    int     fails = 0;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH:0] res;
        longint         acc;
    } exp_t;
    exp_t sb[$];

    bit     b2b_mode = 0;
    bit     b2b_first = 0;
    bit     rand_rdy = 0;
    logic   prev_ov = 1'b0;
    longint last_rise = 0;

    // Reference: plain unsigned addition in WIDTH+1 bits.
    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic c);
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    endfunction

    function automatic logic [WIDTH-1:0] tr(input logic [63:0] v);
        return v[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] rnd();
        logic [63:0] v;
        v = {$urandom, $urandom};
        return v[WIDTH-1:0];
    endfunction

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Called at #1 after an edge; returns at #1 after an edge with in_ready=1.
    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 1000 + 8 * WIDTH) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL wait_ready: in_ready still 0 after %0d cycles, expected 1", n);
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 1000 + 8 * WIDTH) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) begin
            tests++;
            fails++;
            $display("FAIL wait_valid: out_valid still 0 after %0d cycles, expected 1", n);
        end
    endtask

    task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                         input logic tc, input bit expect_it, input bit hold);
        exp_t e;
        a = ta;
        b = tb_v;
        cin = tc;
        in_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        if (expect_it) begin
            e.res = ref_add(ta, tb_v, tc);
            e.acc = cyc;
            sb.push_back(e);
        end
        if (!hold) in_valid = 1'b0;
    endtask

    // Scoreboard monitor: latency/interval on each rising out_valid, value
    // compare on each completed output handshake.
    always @(negedge clk) begin
        if (out_valid && !prev_ov) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got out_valid with sum 0x%0h, expected no result", sum);
            end else begin
                chk("latency", 65'(cyc - sb[0].acc), 65'(WIDTH));
                if (b2b_mode && !b2b_first)
                    chk("interval", 65'(cyc - last_rise), 65'(WIDTH + 2));
            end
            b2b_first = 0;
            last_rise = cyc;
        end
        if (out_valid && out_ready && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("sum", 65'(sum), 65'(e.res[WIDTH-1:0]));
            chk("cout", 65'(cout), 65'(e.res[WIDTH]));
        end
        prev_ov = out_valid;
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        logic [WIDTH:0] r;
        int n;

        // Reset values
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 65'(in_ready), 65'd1);
        chk("rst_out_valid", 65'(out_valid), 65'd0);
        chk("rst_sum", 65'(sum), 65'd0);
        chk("rst_cout", 65'(cout), 65'd0);
        chk("rst_busy", 65'(busy), 65'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic op with exact latency and return to IDLE
        out_ready = 1'b1;
        issue(tr(64'h3C), tr(64'h5A), 1'b0, 1, 0);
        repeat (WIDTH - 1) @(posedge clk);
        #1;
        chk("ov_early", 65'(out_valid), 65'd0);
        chk("busy_run", 65'(busy), 65'd1);
        chk("in_ready_run", 65'(in_ready), 65'd0);
        @(posedge clk); #1;
        chk("ov_on_time", 65'(out_valid), 65'd1);
        chk("in_ready_done", 65'(in_ready), 65'd0);
        @(posedge clk); #1;
        chk("in_ready_back", 65'(in_ready), 65'd1);
        chk("ov_cleared", 65'(out_valid), 65'd0);

        // Carry boundaries
        issue(tr(64'hFF), tr(64'h01), 1'b0, 1, 0);
        issue(tr(64'hFF), tr(64'hFF), 1'b1, 1, 0);
        wait_ready();

        // Backpressure: DONE holds, in_valid ignored
        out_ready = 1'b0;
        issue(tr(64'h81), tr(64'h7F), 1'b1, 1, 0);
        r = ref_add(tr(64'h81), tr(64'h7F), 1'b1);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            a = rnd();
            b = rnd();
            cin = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk("bp_out_valid", 65'(out_valid), 65'd1);
            chk("bp_in_ready", 65'(in_ready), 65'd0);
            chk("bp_sum", 65'(sum), 65'(r[WIDTH-1:0]));
            chk("bp_cout", 65'(cout), 65'(r[WIDTH]));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ov", 65'(out_valid), 65'd0);
        chk("bp_release_ready", 65'(in_ready), 65'd1);
        chk("bp_no_capture", 65'(busy), 65'd0);

        // Operands change after acceptance
        issue(tr(64'h10), tr(64'h20), 1'b0, 1, 0);
        a = tr(64'hAA);
        b = tr(64'h55);
        cin = 1'b1;
        wait_ready();

        // Async reset mid-operation discards the result
        out_ready = 1'b0;
        issue(tr(64'h01), tr(64'h01), 1'b0, 0, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 65'(out_valid), 65'd0);
        chk("ar_sum", 65'(sum), 65'd0);
        chk("ar_cout", 65'(cout), 65'd0);
        chk("ar_busy", 65'(busy), 65'd0);
        chk("ar_in_ready", 65'(in_ready), 65'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        issue(tr(64'h01), tr(64'h01), 1'b0, 1, 0);
        wait_ready();

        // Back-to-back with in_valid and out_ready held high
        b2b_mode = 1;
        b2b_first = 1;
        for (int i = 0; i < 200; i++)
            issue(rnd(), rnd(), 1'($urandom_range(0, 1)), 1, 1);
        in_valid = 1'b0;
        wait_ready();
        b2b_mode = 0;

        // Random traffic with random backpressure and gaps
        rand_rdy = 1;
        for (int i = 0; i < 800; i++) begin
            issue(rnd(), rnd(), 1'($urandom_range(0, 1)), 1, 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
        rand_rdy = 0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
